// File: rtl/bnn_result_tx.sv
// bnn_result_tx: captures class scores on start, finds the winning class with a sequential
// argmax and shifts the frame out MSB first. Define BNN_RESULT_TX_SCORES_EN to append all scores.
module bnn_result_tx #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned SCORE_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_CLASSES*SCORE_W-1:0] scores,
    input  logic                           tx_ready,
    output logic                           tx_bit,
    output logic                           tx_valid,
    output logic                           tx_last,
    output logic [3:0]                     digit,
    output logic                           busy,
    output logic                           done
);
    localparam int unsigned IDX_W     = 4;
    localparam int unsigned SCORES_BW = NUM_CLASSES * SCORE_W;
`ifdef BNN_RESULT_TX_SCORES_EN
    localparam int unsigned FRAME_W   = IDX_W + SCORES_BW;
`else
    localparam int unsigned FRAME_W   = IDX_W;
`endif
    localparam int unsigned CNT_W     = $clog2(FRAME_W);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARGMAX = 2'd1;
    localparam logic [1:0] S_SEND   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]           r_state,    w_state_nxt;
    logic [SCORES_BW-1:0] r_scores,   w_scores_nxt;
    logic [SCORE_W-1:0]   r_best,     w_best_nxt;
    logic [IDX_W-1:0]     r_idx,      w_idx_nxt;
    logic [IDX_W-1:0]     r_i,        w_i_nxt;
    logic [IDX_W-1:0]     r_digit,    w_digit_nxt;
    logic [FRAME_W-1:0]   r_shift,    w_shift_nxt;
    logic [CNT_W-1:0]     r_cnt,      w_cnt_nxt;
    logic                 r_tx_last,  w_tx_last_nxt;
    logic                 r_tx_valid, w_tx_valid_nxt;
    logic                 r_busy,     w_busy_nxt;
    logic                 r_done,     w_done_nxt;

    logic [SCORE_W-1:0]   w_score_i;
    logic [IDX_W-1:0]     w_win;
    logic [FRAME_W-1:0]   w_frame;
    logic                 w_xfer;

    // score currently under comparison
    always_comb begin
        w_score_i = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (r_i == IDX_W'(k)) w_score_i = r_scores[k*SCORE_W +: SCORE_W];
        end
    end

    // strict compare keeps the lower index on ties
    assign w_win  = (w_score_i > r_best) ? r_i : r_idx;
    assign w_xfer = r_tx_valid && tx_ready;

`ifdef BNN_RESULT_TX_SCORES_EN
    logic [SCORES_BW-1:0] w_scores_frame;

    // class 0 goes out first, so it sits just below the digit
    always_comb begin
        w_scores_frame = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            w_scores_frame[(NUM_CLASSES-1-k)*SCORE_W +: SCORE_W] = r_scores[k*SCORE_W +: SCORE_W];
        end
    end
    assign w_frame = {w_win, w_scores_frame};
`else
    assign w_frame = w_win;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_scores_nxt  = r_scores;
        w_best_nxt    = r_best;
        w_idx_nxt     = r_idx;
        w_i_nxt       = r_i;
        w_digit_nxt   = r_digit;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_cnt;
        w_tx_last_nxt = r_tx_last;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_scores_nxt = scores;
                    w_best_nxt   = scores[SCORE_W-1:0];
                    w_idx_nxt    = '0;
                    w_i_nxt      = IDX_W'(1);
                    w_state_nxt  = S_ARGMAX;
                end
            end
            S_ARGMAX: begin
                w_best_nxt = (w_score_i > r_best) ? w_score_i : r_best;
                w_idx_nxt  = w_win;
                if (r_i == IDX_W'(NUM_CLASSES - 1)) begin
                    w_digit_nxt   = w_win;
                    w_shift_nxt   = w_frame;
                    w_cnt_nxt     = '0;
                    w_tx_last_nxt = 1'b0;
                    w_state_nxt   = S_SEND;
                end else begin
                    w_i_nxt = r_i + IDX_W'(1);
                end
            end
            S_SEND: begin
                if (w_xfer) begin
                    w_shift_nxt = r_shift << 1;
                    if (r_tx_last) begin
                        w_tx_last_nxt = 1'b0;
                        w_state_nxt   = S_DONE;
                    end else begin
                        w_cnt_nxt     = r_cnt + CNT_W'(1);
                        w_tx_last_nxt = (r_cnt == CNT_W'(FRAME_W - 2));
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_tx_valid_nxt = (w_state_nxt == S_SEND);
        w_busy_nxt     = (w_state_nxt == S_ARGMAX) || (w_state_nxt == S_SEND);
        w_done_nxt     = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_scores   <= '0;
            r_best     <= '0;
            r_idx      <= '0;
            r_i        <= '0;
            r_digit    <= '0;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_tx_last  <= 1'b0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_scores   <= w_scores_nxt;
            r_best     <= w_best_nxt;
            r_idx      <= w_idx_nxt;
            r_i        <= w_i_nxt;
            r_digit    <= w_digit_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tx_last  <= w_tx_last_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign tx_bit   = r_shift[FRAME_W-1];
    assign tx_valid = r_tx_valid;
    assign tx_last  = r_tx_last;
    assign digit    = r_digit;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_bnn_result_tx.sv
// Scoreboard bench for bnn_result_tx: stimulus queues expected frame bits, a negedge monitor
// pops and compares them on every accepted transfer. Honours BNN_RESULT_TX_SCORES_EN.
module tb_bnn_result_tx;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [79:0] scores;
    logic        tx_ready;
    logic        tx_bit;
    logic        tx_valid;
    logic        tx_last;
    logic [3:0]  digit;
    logic        busy;
    logic        done;

`ifdef BNN_RESULT_TX_SCORES_EN
    localparam int FRAME_BITS = 84;
`else
    localparam int FRAME_BITS = 4;
`endif

    bnn_result_tx #(.NUM_CLASSES(10), .SCORE_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .scores(scores), .tx_ready(tx_ready),
        .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_last(tx_last),
        .digit(digit), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int xfer_cnt = 0;
    int last_xfer_cyc = -10;
    logic [1:0] exp_q[$];   // {bit, last}

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: stall stability and scoreboard pop on each transfer
    logic stall_prev = 1'b0;
    logic prev_bit   = 1'b0;
    logic prev_last  = 1'b0;
    always @(negedge clk) begin
        logic [1:0] e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", int'(tx_valid), 1);
                chk("stall_bit", int'(tx_bit), int'(prev_bit));
                chk("stall_last", int'(tx_last), int'(prev_last));
            end
            if (tx_valid && tx_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_bit", int'(tx_bit), int'(e[1]));
                    chk("frame_last", int'(tx_last), int'(e[0]));
                end
                if (tx_last) last_xfer_cyc = cyc;
            end
            stall_prev = tx_valid && !tx_ready;
            prev_bit   = tx_bit;
            prev_last  = tx_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [79:0] pack(input int unsigned v[10]);
        logic [79:0] r;
        r = '0;
        for (int k = 0; k < 10; k++) r[k*8 +: 8] = 8'(v[k]);
        return r;
    endfunction

    task automatic push_frame(input logic [3:0] d, input logic [79:0] sc);
        int k;
        k = 0;
        for (int b = 3; b >= 0; b--) begin
            exp_q.push_back({d[b], 1'(k == FRAME_BITS - 1)});
            k++;
        end
`ifdef BNN_RESULT_TX_SCORES_EN
        for (int c = 0; c < 10; c++) begin
            for (int b = 7; b >= 0; b--) begin
                exp_q.push_back({sc[c*8 + b], 1'(k == FRAME_BITS - 1)});
                k++;
            end
        end
`else
        if (sc[0] === 1'bx) k = 0;
`endif
    endtask

    // One full frame: start, optional backpressure pattern, optional ignored start pulses
    task automatic run_frame(input logic [79:0] sc, input logic [3:0] d, input logic [3:0] d_prev,
                             input bit bp, input bit poke);
        int  s_cyc, j, budget, x0;
        bit  seen_valid;
        bit  pat[7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        push_frame(d, sc);
        x0 = xfer_cnt;
        scores   = sc;
        start    = 1'b1;
        tx_ready = bp ? 1'b0 : 1'b1;
        tick();
        s_cyc = cyc;
        start = 1'b0;
        chk("busy_argmax", int'(busy), 1);
        chk("done_argmax", int'(done), 0);
        chk("digit_hold_argmax", int'(digit), int'(d_prev));
        seen_valid = 1'b0;
        j = 0;
        budget = 0;
        while (!done && budget < 400) begin
            if (tx_valid && !seen_valid) begin
                seen_valid = 1'b1;
                chk("start_latency", cyc - s_cyc + 1, 10);
                chk("digit_at_send", int'(digit), int'(d));
                if (poke) begin
                    scores = ~sc;
                    start  = 1'b1;
                end
            end
            if (tx_valid && bp) begin
                tx_ready = (j < 7) ? pat[j] : 1'b1;
                j++;
            end
            if (poke && (cyc - s_cyc == 3)) begin
                scores = ~sc;
                start  = 1'b1;
            end
            tick();
            start = 1'b0;
            budget++;
        end
        if (!done) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("done_after_last", cyc, last_xfer_cyc + 1);
            chk("digit_done", int'(digit), int'(d));
            chk("valid_in_done", int'(tx_valid), 0);
            chk("busy_in_done", int'(busy), 0);
            chk("xfer_count", xfer_cnt - x0, FRAME_BITS);
            chk("frame_complete", exp_q.size(), 0);
        end
        exp_q.delete();
        tx_ready = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned va[10], vb[10], vc[10], vd[10];
        logic [79:0] sa, sb, sc, sd;
        int x0, budget;
        va = '{3, 9, 1, 14, 14, 2, 0, 7, 5, 13};
        vb = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 8'hA5};
        vc = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        vd = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
        sa = pack(va);
        sb = pack(vb);
        sc = pack(vc);
        sd = pack(vd);

        rst = 1'b1; start = 1'b0; tx_ready = 1'b0; scores = '0;
        tick();
        tick();
        rst = 1'b0;
        tx_ready = 1'b1;
        tick();
        tick();
        chk("rst_tx_bit", int'(tx_bit), 0);
        chk("rst_tx_valid", int'(tx_valid), 0);
        chk("rst_tx_last", int'(tx_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_digit", int'(digit), 0);

        run_frame(sa, 4'd3, 4'd0, 1'b0, 1'b0);
        run_frame(sa, 4'd3, 4'd3, 1'b1, 1'b0);
        run_frame(sb, 4'd9, 4'd3, 1'b0, 1'b0);
        run_frame(sd, 4'd0, 4'd9, 1'b0, 1'b0);

        // abandon a frame after two transfers
        push_frame(4'd3, sa);
        x0 = xfer_cnt;
        scores = sa; start = 1'b1; tx_ready = 1'b1;
        tick();
        start = 1'b0;
        budget = 0;
        while ((xfer_cnt - x0) < 2 && budget < 100) begin
            tick();
            budget++;
        end
        chk("two_xfers_before_rst", xfer_cnt - x0, 2);
        rst = 1'b1;
        tx_ready = 1'b0;
        tick();
        rst = 1'b0;
        chk("midrst_tx_bit", int'(tx_bit), 0);
        chk("midrst_tx_valid", int'(tx_valid), 0);
        chk("midrst_tx_last", int'(tx_last), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_digit", int'(digit), 0);
        exp_q.delete();
        tx_ready = 1'b1;
        tick();
        run_frame(sa, 4'd3, 4'd0, 1'b0, 1'b0);

        // start ignored in ARGMAX/SEND, then honoured from DONE
        run_frame(sa, 4'd3, 4'd3, 1'b0, 1'b1);
        run_frame(sc, 4'd6, 4'd3, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/bnn_result_tx.md
# bnn_result_tx

Result-side counterpart of the serial pixel/weight loader. Once the layer-3 stage signals completion, it captures the per-class popcount scores, picks the winning digit by a sequential argmax, and shifts the result out to the host one bit per accepted handshake on dedicated output pins. It sits after the layer-3 datapath, and the top FSM drives its `start`.

## Interface
- `NUM_CLASSES`, default 10: number of class scores. Legal range is 2..16.
- `SCORE_W`, default 8: width in bits of each unsigned popcount score.

Ports (clock and reset first):
- `clk`  input  1  single design clock.
- `rst`  input  1  reset; synchronous, active-high.
- `start`  input  1  one-cycle pulse from the top FSM when layer 3 is done.
- `scores`  input  NUM_CLASSES*SCORE_W  flattened unsigned scores. Class k occupies bits [k*SCORE_W +: SCORE_W].
- `tx_ready`  input  1  host is ready to accept the current bit.
- `tx_bit`  output  1  current serial data bit.
- `tx_valid`  output  1  `tx_bit` is valid.
- `tx_last`  output  1  high together with `tx_valid` on the final bit of the frame.
- `digit`  output  4  winning class index.
- `busy`  output  1  high in ARGMAX and SEND.
- `done`  output  1  high in DONE.

## Operation
State machine with four states: IDLE, ARGMAX, SEND, DONE.

- **IDLE**
  - On `start`: latch `scores` into an internal register, set best = score[0], idx = 0, i = 1, and go to ARGMAX.
  - Otherwise remain in IDLE.
- **ARGMAX**
  - Each cycle, if score[i] > best (strictly greater), update best and idx.
  - Increment i. After comparing i = NUM_CLASSES-1, load the frame shifter and go to SEND.
  - Ties keep the lower index.
  - Compare unsigned at the full SCORE_W width; no truncation.
- **SEND**
  - Frame content is the 4-bit `digit`, sent MSB first (see Configuration).
  - A bit transfers on every cycle with `tx_valid && tx_ready`. The shifter advances only on a transfer.
  - While `tx_valid && !tx_ready`, `tx_bit` and `tx_last` hold steady.
  - `tx_last` goes high on the final bit. A transfer of that bit moves the FSM to DONE.
- **DONE**
  - `digit` holds its value and `done` = 1.
  - `start` returns the FSM to the IDLE capture path, i.e. it behaves as `start` in IDLE on the same edge.
- `start` is ignored while in ARGMAX or SEND.
- `digit` updates only on the ARGMAX→SEND transition. It holds its value through SEND, DONE and IDLE until the next argmax completes.
- The bit counter is sized to hold the frame length and does not wrap within a frame.

## Timing
- **Reset** (any state, including mid-frame): next state is IDLE. After the reset edge, `tx_bit`, `tx_valid`, `tx_last`, `busy` and `done` are all 0, and `digit` = 0. A partially sent frame is abandoned and not resumed.
- **`rst` and `start` in the same cycle:** reset wins.
- **Start latency:** with `start` sampled at edge 0, ARGMAX occupies the cycles after edges 0..NUM_CLASSES-2. SEND is entered at edge NUM_CLASSES-1, so `tx_valid` first goes high NUM_CLASSES cycles after the start edge (10 cycles by default).
- **Throughput:** one bit per cycle while `tx_ready` is held high.
- **Frame duration:** minimum frame length F cycles. The `done` rise is registered: it appears the cycle after the last transfer.
- **`tx_valid` timing:** `tx_valid` is never high outside SEND. It stays high continuously from SEND entry to the last transfer.
- **Early `tx_ready`:** `tx_ready` high before `tx_valid` has no effect.

## Configuration
- `BNN_RESULT_TX_SCORES_EN` defined:
  - The frame is the 4-bit digit followed by every score. Scores are sent class 0 first, each MSB first.
  - F = 4 + NUM_CLASSES*SCORE_W (84 bits by default).
  - The captured score register is retained through SEND.
- `BNN_RESULT_TX_SCORES_EN` undefined:
  - The frame is the 4-bit digit only, so F = 4.
  - The score shift path is not built.
  - Argmax behaviour is identical in both configurations.

## Test plan
- **Reset values:** assert `rst` for 2 cycles, then idle → all outputs are 0 and the FSM is in IDLE. Pulse `start` with `tx_ready` = 1 → `tx_valid` rises exactly 10 cycles after the start edge.
- **Argmax, digit-only build:** scores = {3,9,1,14,14,2,0,7,5,13} (class 0 first), `tx_ready` held at 1 → `digit` = 3 (tie resolves to the lower index). Bits sent are 0,0,1,1 with `tx_last` on the 4th bit, and `done` rises the following cycle.
- **Backpressure:** same scores, with `tx_ready` toggling 1,0,0,1,0,1,1 → `tx_bit` and `tx_last` stay stable across each stall. Exactly 4 transfers occur, with no bit duplicated or dropped.
- **Scores build:** scores all 0 except class 9 = 8'hA5 → `digit` = 9. The frame is 84 bits: 1001, then 72 zeros, then 10100101. `tx_last` is high only on bit 84.
- **Reset mid-frame:** assert `rst` after 2 transfers → outputs are 0 the next cycle. A fresh `start` then yields a complete frame from bit 1.
- **Start handling:** `start` pulsed during ARGMAX and during SEND is ignored and the frame is unchanged. `start` in DONE with new scores {0,…,0,1 at class 6} → `digit` = 6 and a new frame is sent.
